// File: rtl/sdram_port_scheduler_pkg.sv
// Shared definitions for the SDRAM port scheduler: defaults, port indices, FSM states
// and the round-robin pick helper.
package sdram_port_scheduler_pkg;

  localparam int unsigned SCHED_ASIZE = 22;
  localparam int unsigned SCHED_LEN_W = 9;
  localparam int unsigned NUM_PORTS   = 4;

  localparam logic [1:0] PORT_WR1 = 2'd0;
  localparam logic [1:0] PORT_WR2 = 2'd1;
  localparam logic [1:0] PORT_RD1 = 2'd2;
  localparam logic [1:0] PORT_RD2 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // First eligible port searching last+1 .. last+4; later iterations override earlier,
  // so the loop runs from lowest to highest priority.
  function automatic pick_t rr_pick(input logic [3:0] elig, input logic [1:0] last);
    pick_t      r;
    logic [1:0] cand;
    r = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (elig[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sdram_port_scheduler_addr_gen.sv
// Per-port address/length registers: load, advance with wrap to start, and
// FIFO-level eligibility.
module sdram_port_scheduler_addr_gen
  import sdram_port_scheduler_pkg::*;
#(
  parameter int unsigned ASIZE = SCHED_ASIZE,
  parameter int unsigned LEN_W = SCHED_LEN_W,
  parameter bit          IS_RD = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             load,
  input  logic             advance,
  input  logic [ASIZE-1:0] start_addr,
  input  logic [ASIZE-1:0] max_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [LEN_W-1:0] level,
  output logic [ASIZE-1:0] addr,
  output logic [LEN_W-1:0] len,
  output logic             eligible_c
);

  logic [ASIZE:0] sum_c;

  // One extra bit so a region ending at the top of the address space compares correctly.
  assign sum_c = {1'b0, addr} + (ASIZE+1)'(len);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr <= '0;
      len  <= '0;
    end else if (load) begin
      addr <= start_addr;
      len  <= length;
    end else if (advance) begin
      addr <= (sum_c < {1'b0, max_addr}) ? sum_c[ASIZE-1:0] : start_addr;
    end
  end

  // Writes need a full burst buffered; reads need room for a full burst.
  always_comb begin
    eligible_c = 1'b0;
    if (len != '0) begin
      eligible_c = IS_RD ? (level < len) : (level >= len);
    end
  end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Round-robin burst scheduler for the 4-port SDRAM controller (WR1/WR2/RD1/RD2).
// Define SDRAM_SCHED_WRITE_PRIORITY_EN to let eligible writes always beat reads.
module sdram_port_scheduler
  import sdram_port_scheduler_pkg::*;
#(
  parameter int unsigned ASIZE = SCHED_ASIZE,
  parameter int unsigned LEN_W = SCHED_LEN_W
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [NUM_PORTS-1:0]     PORT_LOAD,
  input  logic [NUM_PORTS*ASIZE-1:0] PORT_ADDR,
  input  logic [NUM_PORTS*ASIZE-1:0] PORT_MAX_ADDR,
  input  logic [NUM_PORTS*LEN_W-1:0] PORT_LENGTH,
  input  logic [NUM_PORTS*LEN_W-1:0] PORT_LEVEL,
  input  logic                     SEQ_IDLE,
  input  logic                     WR_DONE,
  input  logic                     RD_DONE,
  output logic                     REQ_WR,
  output logic                     REQ_RD,
  output logic [ASIZE-1:0]         REQ_ADDR,
  output logic [LEN_W-1:0]         REQ_LENGTH,
  output logic [1:0]               WR_MASK,
  output logic [1:0]               RD_MASK
);

  logic [ASIZE-1:0]     addr_q [NUM_PORTS];
  logic [LEN_W-1:0]     len_q  [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig_c;
  logic [NUM_PORTS-1:0] arb_elig_c;
  logic [NUM_PORTS-1:0] advance_c;
  pick_t                pick_c;

  sched_state_e     state_q, state_d;
  logic [1:0]       last_gnt_q, last_gnt_d;
  logic             skip_adv_q, skip_adv_d;
  logic             req_wr_d, req_rd_d;
  logic [ASIZE-1:0] req_addr_d;
  logic [LEN_W-1:0] req_len_d;
  logic [1:0]       wr_mask_d, rd_mask_d;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    sdram_port_scheduler_addr_gen #(
      .ASIZE (ASIZE),
      .LEN_W (LEN_W),
      .IS_RD (p >= 2)
    ) u_addr_gen (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .load       (PORT_LOAD[p]),
      .advance    (advance_c[p]),
      .start_addr (PORT_ADDR[p*ASIZE +: ASIZE]),
      .max_addr   (PORT_MAX_ADDR[p*ASIZE +: ASIZE]),
      .length     (PORT_LENGTH[p*LEN_W +: LEN_W]),
      .level      (PORT_LEVEL[p*LEN_W +: LEN_W]),
      .addr       (addr_q[p]),
      .len        (len_q[p]),
      .eligible_c (elig_c[p])
    );
  end

`ifdef SDRAM_SCHED_WRITE_PRIORITY_EN
  // Reads only compete when no write port is ready.
  assign arb_elig_c = (|elig_c[1:0]) ? {2'b00, elig_c[1:0]} : {elig_c[3:2], 2'b00};
`else
  assign arb_elig_c = elig_c;
`endif

  assign pick_c = rr_pick(arb_elig_c, last_gnt_q);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 2'd3;
      skip_adv_q <= 1'b0;
      REQ_WR     <= 1'b0;
      REQ_RD     <= 1'b0;
      REQ_ADDR   <= '0;
      REQ_LENGTH <= '0;
      WR_MASK    <= 2'b00;
      RD_MASK    <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      skip_adv_q <= skip_adv_d;
      REQ_WR     <= req_wr_d;
      REQ_RD     <= req_rd_d;
      REQ_ADDR   <= req_addr_d;
      REQ_LENGTH <= req_len_d;
      WR_MASK    <= wr_mask_d;
      RD_MASK    <= rd_mask_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    skip_adv_d = skip_adv_q;
    req_wr_d   = REQ_WR;
    req_rd_d   = REQ_RD;
    req_addr_d = REQ_ADDR;
    req_len_d  = REQ_LENGTH;
    wr_mask_d  = WR_MASK;
    rd_mask_d  = RD_MASK;
    advance_c  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (SEQ_IDLE && (PORT_LOAD == '0) && pick_c.found) begin
          state_d    = ST_GRANT;
          last_gnt_d = pick_c.idx;
          skip_adv_d = 1'b0;
          req_addr_d = addr_q[pick_c.idx];
          req_len_d  = len_q[pick_c.idx];
          unique case (pick_c.idx)
            PORT_WR1: wr_mask_d = 2'b01;
            PORT_WR2: wr_mask_d = 2'b10;
            PORT_RD1: rd_mask_d = 2'b01;
            PORT_RD2: rd_mask_d = 2'b10;
          endcase
        end
      end

      ST_GRANT: begin
        state_d  = ST_BUSY;
        req_wr_d = |WR_MASK;
        req_rd_d = |RD_MASK;
        if (PORT_LOAD[last_gnt_q]) skip_adv_d = 1'b1;
      end

      ST_BUSY: begin
        // A reload of the granted port replaces the advance for this burst.
        if (PORT_LOAD[last_gnt_q]) skip_adv_d = 1'b1;
        if ((REQ_WR && WR_DONE) || (REQ_RD && RD_DONE)) begin
          state_d   = ST_DONE;
          req_wr_d  = 1'b0;
          req_rd_d  = 1'b0;
          wr_mask_d = 2'b00;
          rd_mask_d = 2'b00;
        end
      end

      ST_DONE: begin
        advance_c[last_gnt_q] = ~skip_adv_q;
        state_d               = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed, table-driven bench for sdram_port_scheduler (default 4-way round robin;
// expected grant order switches when SDRAM_SCHED_WRITE_PRIORITY_EN is defined).
module tb_sdram_port_scheduler;

  localparam int AW = 22;
  localparam int LW = 9;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [3:0]    PORT_LOAD;
  logic [4*AW-1:0] PORT_ADDR, PORT_MAX_ADDR;
  logic [4*LW-1:0] PORT_LENGTH, PORT_LEVEL;
  logic          SEQ_IDLE, WR_DONE, RD_DONE;
  logic          REQ_WR, REQ_RD;
  logic [AW-1:0] REQ_ADDR;
  logic [LW-1:0] REQ_LENGTH;
  logic [1:0]    WR_MASK, RD_MASK;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] cfg_start [4];
  logic [AW-1:0] cfg_max   [4];
  logic [LW-1:0] cfg_len   [4];

  typedef struct {
    logic [3:0]    elig;
    int            port;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } vec_t;

  vec_t vecs [15];

  sdram_port_scheduler dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .PORT_LOAD     (PORT_LOAD),
    .PORT_ADDR     (PORT_ADDR),
    .PORT_MAX_ADDR (PORT_MAX_ADDR),
    .PORT_LENGTH   (PORT_LENGTH),
    .PORT_LEVEL    (PORT_LEVEL),
    .SEQ_IDLE      (SEQ_IDLE),
    .WR_DONE       (WR_DONE),
    .RD_DONE       (RD_DONE),
    .REQ_WR        (REQ_WR),
    .REQ_RD        (REQ_RD),
    .REQ_ADDR      (REQ_ADDR),
    .REQ_LENGTH    (REQ_LENGTH),
    .WR_MASK       (WR_MASK),
    .RD_MASK       (RD_MASK)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int idx, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] %s: got %0h want %0h", tag, idx, field, act, exp);
    end
  endtask

  task automatic drive_cfg();
    for (int p = 0; p < 4; p++) begin
      PORT_ADDR[p*AW +: AW]     = cfg_start[p];
      PORT_MAX_ADDR[p*AW +: AW] = cfg_max[p];
      PORT_LENGTH[p*LW +: LW]   = cfg_len[p];
    end
  endtask

  // Writes eligible at level 300 (>= 256), reads eligible at level 0, ineligible at 511.
  task automatic set_elig(input logic [3:0] m);
    for (int p = 0; p < 4; p++) begin
      if (p < 2) PORT_LEVEL[p*LW +: LW] = m[p] ? 9'd300 : 9'd0;
      else       PORT_LEVEL[p*LW +: LW] = m[p] ? 9'd0   : 9'd511;
    end
  endtask

  task automatic load_ports(input logic [3:0] m);
    drive_cfg();
    PORT_LOAD = m;
    @(negedge CLK);
    PORT_LOAD = 4'h0;
  endtask

  task automatic wait_req(input string tag, input int idx, output bit ok);
    int n = 0;
    while (!(REQ_WR || REQ_RD) && n < 64) begin
      @(negedge CLK);
      n++;
    end
    ok = (n < 64);
    chk(tag, idx, "req_seen", 32'(ok), 32'd1);
  endtask

  // Waits for a request, checks it, then completes it with the matching DONE pulse.
  task automatic do_burst(input string tag, input int idx, input int port,
                          input logic [AW-1:0] addr, input logic [LW-1:0] len,
                          input logic [3:0] load_mask);
    bit         ok;
    logic [3:0] onehot;
    wait_req(tag, idx, ok);
    if (ok) begin
      onehot = 4'(1 << port);
      chk(tag, idx, "masks", 32'({RD_MASK, WR_MASK}), 32'(onehot));
      chk(tag, idx, "req", 32'({REQ_RD, REQ_WR}), (port < 2) ? 32'd1 : 32'd2);
      chk(tag, idx, "addr", 32'(REQ_ADDR), 32'(addr));
      chk(tag, idx, "len", 32'(REQ_LENGTH), 32'(len));
      PORT_LOAD = load_mask;
      if (port < 2) WR_DONE = 1'b1;
      else          RD_DONE = 1'b1;
      @(negedge CLK);
      PORT_LOAD = 4'h0;
      WR_DONE   = 1'b0;
      RD_DONE   = 1'b0;
      chk(tag, idx, "released", 32'({REQ_RD, REQ_WR, RD_MASK, WR_MASK}), 32'd0);
    end
  endtask

  initial begin
    bit ok;

    cfg_start = '{22'h000000, 22'h002000, 22'h010000, 22'h020000};
    cfg_max   = '{22'h000400, 22'h002300, 22'h010080, 22'h030000};
    cfg_len   = '{9'd256, 9'd256, 9'd64, 9'd16};

    vecs[0] = '{4'b0001, 0, 22'h000000, 9'd256};
    vecs[1] = '{4'b0001, 0, 22'h000100, 9'd256};
    vecs[2] = '{4'b0001, 0, 22'h000200, 9'd256};
    vecs[3] = '{4'b0001, 0, 22'h000300, 9'd256};
    vecs[4] = '{4'b0001, 0, 22'h000000, 9'd256};
`ifdef SDRAM_SCHED_WRITE_PRIORITY_EN
    vecs[5]  = '{4'b1111, 1, 22'h002000, 9'd256};
    vecs[6]  = '{4'b1111, 0, 22'h000100, 9'd256};
    vecs[7]  = '{4'b1111, 1, 22'h002100, 9'd256};
    vecs[8]  = '{4'b1111, 0, 22'h000200, 9'd256};
    vecs[9]  = '{4'b1111, 1, 22'h002200, 9'd256};
    vecs[10] = '{4'b1111, 0, 22'h000300, 9'd256};
    vecs[11] = '{4'b1111, 1, 22'h002000, 9'd256};
    vecs[12] = '{4'b1111, 0, 22'h000000, 9'd256};
    vecs[13] = '{4'b1100, 2, 22'h010000, 9'd64};
    vecs[14] = '{4'b1100, 3, 22'h020000, 9'd16};
`else
    vecs[5]  = '{4'b1111, 1, 22'h002000, 9'd256};
    vecs[6]  = '{4'b1111, 2, 22'h010000, 9'd64};
    vecs[7]  = '{4'b1111, 3, 22'h020000, 9'd16};
    vecs[8]  = '{4'b1111, 0, 22'h000100, 9'd256};
    vecs[9]  = '{4'b1111, 1, 22'h002100, 9'd256};
    vecs[10] = '{4'b1111, 2, 22'h010040, 9'd64};
    vecs[11] = '{4'b1111, 3, 22'h020010, 9'd16};
    vecs[12] = '{4'b1111, 0, 22'h000200, 9'd256};
    vecs[13] = '{4'b1100, 2, 22'h010000, 9'd64};
    vecs[14] = '{4'b1100, 3, 22'h020020, 9'd16};
`endif

    RESET_N     = 1'b0;
    PORT_LOAD   = 4'h0;
    PORT_ADDR   = '0;
    PORT_MAX_ADDR = '0;
    PORT_LENGTH = '0;
    PORT_LEVEL  = {4{9'd300}};
    SEQ_IDLE    = 1'b1;
    WR_DONE     = 1'b0;
    RD_DONE     = 1'b0;

    // Reset values
    #1;
    chk("reset", 0, "outs", 32'({REQ_WR, REQ_RD, WR_MASK, RD_MASK}), 32'd0);
    chk("reset", 0, "addr_len", 32'(REQ_ADDR) | 32'(REQ_LENGTH), 32'd0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;

    // Test 1: all ports disabled, stray DONE pulses ignored
    for (int i = 0; i < 20; i++) begin
      WR_DONE = (i == 5);
      RD_DONE = (i == 9);
      @(negedge CLK);
      chk("t1", i, "outs", 32'({REQ_WR, REQ_RD, WR_MASK, RD_MASK, REQ_ADDR}), 32'd0);
    end
    WR_DONE = 1'b0;
    RD_DONE = 1'b0;

    // Test 2 latency: grant registered one cycle, request the next
    set_elig(4'b0000);
    load_ports(4'hF);
    set_elig(4'b0001);
    @(negedge CLK);
    chk("lat", 0, "grant_mask", 32'({REQ_WR, REQ_RD, WR_MASK, RD_MASK}), 32'b0001_00);
    @(negedge CLK);
    chk("lat", 1, "request", 32'({REQ_WR, REQ_RD, WR_MASK, RD_MASK}), 32'b1001_00);

    // Tests 2 and 3: table of bursts
    for (int i = 0; i < 15; i++) begin
      set_elig(vecs[i].elig);
      do_burst("vec", i, vecs[i].port, vecs[i].addr, vecs[i].len, 4'h0);
    end
    set_elig(4'b0000);

    // Test 4: reload RD1 and stray WR_DONE while RD2 is busy
    load_ports(4'hF);
    set_elig(4'b1000);
    wait_req("t4", 0, ok);
    if (ok) begin
      chk("t4", 0, "addr", 32'(REQ_ADDR), 32'h020000);
      cfg_start[2] = 22'h100000;
      drive_cfg();
      PORT_LOAD = 4'b0100;
      WR_DONE   = 1'b1;
      @(negedge CLK);
      PORT_LOAD = 4'h0;
      WR_DONE   = 1'b0;
      chk("t4", 1, "held", 32'({REQ_RD, REQ_WR, RD_MASK, WR_MASK}), 32'b10_10_00);
      @(negedge CLK);
      chk("t4", 2, "held_addr", 32'({REQ_RD, REQ_ADDR}), 32'({1'b1, 22'h020000}));
    end
    set_elig(4'b0100);
    do_burst("t4rd2", 3, 3, 22'h020000, 9'd16, 4'h0);
    do_burst("t4rd1", 4, 2, 22'h100000, 9'd64, 4'h0);
    set_elig(4'b0000);

    // Test 6: reload coincident with WR_DONE wins over advance; then wrap to new start
    cfg_start[2] = 22'h010000;
    load_ports(4'hF);
    cfg_start[0] = 22'h000300;
    drive_cfg();
    set_elig(4'b0001);
    do_burst("t6", 0, 0, 22'h000000, 9'd256, 4'b0001);
    do_burst("t6", 1, 0, 22'h000300, 9'd256, 4'h0);
    do_burst("t6", 2, 0, 22'h000300, 9'd256, 4'h0);

    // Test 5: async reset mid-burst clears outputs and grant history at once
    wait_req("t5", 0, ok);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t5", 1, "outs", 32'({REQ_WR, REQ_RD, WR_MASK, RD_MASK}), 32'd0);
    chk("t5", 2, "addr_len", 32'(REQ_ADDR) | 32'(REQ_LENGTH), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    cfg_start[0] = 22'h000000;
    set_elig(4'b0000);
    load_ports(4'hF);
    set_elig(4'b1111);
    do_burst("t5", 3, 0, 22'h000000, 9'd256, 4'h0);
    do_burst("t5", 4, 1, 22'h002000, 9'd256, 4'h0);
    set_elig(4'b0000);
    repeat (4) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
